// File: rtl/wb_xbar_mmu_if.sv
// Wishbone bus bundle for wb_xbar_mmu: NMASTERS classic-cycle master ports
// on one side, 16 slave slots on the other. The "slave" modport is the
// interconnect's view (it is the slave of the masters); "master" is the
// view of the surrounding masters and slots that drive it.
interface wb_xbar_mmu_if #(
  parameter int unsigned NMASTERS = 2
);
  logic [NMASTERS-1:0]    m_cyc;
  logic [NMASTERS-1:0]    m_stb;
  logic [NMASTERS-1:0]    m_we;
  logic [4*NMASTERS-1:0]  m_sel;
  logic [32*NMASTERS-1:0] m_adr;
  logic [32*NMASTERS-1:0] m_dat_w;
  logic [31:0]            m_dat_r;
  logic [NMASTERS-1:0]    m_ack;
  logic [NMASTERS-1:0]    m_err;

  logic [15:0]            s_cyc;
  logic [15:0]            s_stb;
  logic                   s_we;
  logic [3:0]             s_sel;
  logic [31:0]            s_adr;
  logic [31:0]            s_dat_w;
  logic [511:0]           s_dat_r;
  logic [15:0]            s_ack;

  modport slave (
    input  m_cyc, m_stb, m_we, m_sel, m_adr, m_dat_w,
    output m_dat_r, m_ack, m_err,
    output s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_w,
    input  s_dat_r, s_ack
  );

  modport master (
    output m_cyc, m_stb, m_we, m_sel, m_adr, m_dat_w,
    input  m_dat_r, m_ack, m_err,
    input  s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_w,
    output s_dat_r, s_ack
  );
endinterface

// File: rtl/wb_xbar_mmu.sv
// Wishbone interconnect with MMU-style slot decode: round-robin arbitration of
// NMASTERS classic-cycle masters onto one shared path (grant held for the
// whole cyc), 4-bit page decode to 16 slots, and bus-error generation for
// unpopulated slots and stalled slaves with fault capture for the interrupt.
module wb_xbar_mmu #(
  parameter int unsigned NMASTERS  = 2,
  parameter int unsigned BASE      = 28,
  parameter logic [15:0] SLOT_MASK = 16'hffff,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  wb_xbar_mmu_if.slave  bus,
  output logic          fault,
  output logic [31:0]   fault_adr,
  output logic [2:0]    fault_master,
  output logic          fault_kind
);
  localparam int unsigned NM = NMASTERS;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_ERR} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_grant, r_last, w_arb_grant;
  logic        w_arb_any;
  logic [15:0] r_wait, w_wait_nxt;
  logic [31:0] r_fault_adr;
  logic [2:0]  r_fault_master;
  logic        r_fault_kind;

  logic        w_cyc, w_stb, w_we;
  logic [3:0]  w_sel;
  logic [31:0] w_adr, w_dat_w;
  logic [3:0]  w_slot;
  logic        w_mapped, w_slot_ack;
  logic [31:0] w_slot_dat;

  logic        w_to_err, w_err_kind, w_release, w_g_ack, w_g_err, w_fault;
  logic [15:0] w_s_cyc, w_s_stb;
  logic        w_s_we;
  logic [3:0]  w_s_sel;
  logic [31:0] w_s_adr, w_s_dat_w, w_m_dat_r;
  logic [NM-1:0] w_m_ack, w_m_err;

  // Select the granted master's signals and decode its target slot
  always_comb begin
    w_cyc   = 1'b0;
    w_stb   = 1'b0;
    w_we    = 1'b0;
    w_sel   = '0;
    w_adr   = '0;
    w_dat_w = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (r_grant == 3'(i)) begin
        w_cyc   = bus.m_cyc[i];
        w_stb   = bus.m_stb[i];
        w_we    = bus.m_we[i];
        w_sel   = bus.m_sel[4*i +: 4];
        w_adr   = bus.m_adr[32*i +: 32];
        w_dat_w = bus.m_dat_w[32*i +: 32];
      end
    end
    w_slot     = w_adr[BASE +: 4];
    w_mapped   = SLOT_MASK[w_slot];
    w_slot_ack = bus.s_ack[w_slot];
    w_slot_dat = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      if (w_slot == 4'(k)) w_slot_dat = bus.s_dat_r[32*k +: 32];
    end
  end

  // Round-robin pick: first requesting master after r_last, scanning cyclically
  always_comb begin
    w_arb_any   = 1'b0;
    w_arb_grant = r_grant;
    for (int unsigned i = 1; i <= NM; i++) begin
      for (int unsigned j = 0; j < NM; j++) begin
        if (!w_arb_any && bus.m_cyc[j] && (((32'(r_last) + i) % NM) == j)) begin
          w_arb_any   = 1'b1;
          w_arb_grant = 3'(j);
        end
      end
    end
  end

  // Next state, wait counter and bus routing for the current grant
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_to_err    = 1'b0;
    w_err_kind  = 1'b0;
    w_release   = 1'b0;
    w_g_ack     = 1'b0;
    w_g_err     = 1'b0;
    w_fault     = 1'b0;
    w_s_cyc     = '0;
    w_s_stb     = '0;
    w_s_we      = 1'b0;
    w_s_sel     = '0;
    w_s_adr     = '0;
    w_s_dat_w   = '0;
    w_m_dat_r   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_arb_any) begin
          w_state_nxt = S_ACTIVE;
          w_wait_nxt  = '0;
        end
      end
      S_ACTIVE: begin
        w_s_we    = w_we;
        w_s_sel   = w_sel;
        w_s_adr   = w_adr;
        w_s_dat_w = w_dat_w;
        if (!w_cyc) begin
          w_state_nxt = S_IDLE;
          w_release   = 1'b1;
          w_wait_nxt  = '0;
        end else if (w_stb && !w_mapped) begin
          w_state_nxt = S_ERR;
          w_to_err    = 1'b1;
          w_err_kind  = 1'b0;
          w_wait_nxt  = '0;
        end else begin
          // s_stb must not depend on s_ack: the timeout cycle itself still
          // passes the strobe through, the drop happens in ERR.
          if (w_mapped) begin
            w_s_cyc   = 16'h0001 << w_slot;
            w_s_stb   = 16'(w_stb) << w_slot;
            w_g_ack   = w_slot_ack;
            w_m_dat_r = w_slot_dat;
          end
          if (w_stb && !w_slot_ack) begin
            if (r_wait == 16'(TIMEOUT)) begin
              w_state_nxt = S_ERR;
              w_to_err    = 1'b1;
              w_err_kind  = 1'b1;
              w_wait_nxt  = '0;
            end else begin
              w_wait_nxt = r_wait + 16'd1;
            end
          end else begin
            w_wait_nxt = '0;
          end
        end
      end
      S_ERR: begin
        w_s_we     = w_we;
        w_s_sel    = w_sel;
        w_s_adr    = w_adr;
        w_s_dat_w  = w_dat_w;
        w_g_err    = 1'b1;
        w_fault    = 1'b1;
        w_wait_nxt = '0;
        if (w_cyc) begin
          w_state_nxt = S_ACTIVE;
        end else begin
          w_state_nxt = S_IDLE;
          w_release   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_wait_nxt  = '0;
      end
    endcase
  end

  // Steer the granted master's ack/err back to its own port only
  always_comb begin
    w_m_ack = '0;
    w_m_err = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (r_grant == 3'(i)) begin
        w_m_ack[i] = w_g_ack;
        w_m_err[i] = w_g_err;
      end
    end
  end

  // State, grant, round-robin pointer, wait counter and fault capture
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state        <= S_IDLE;
      r_grant        <= '0;
      r_last         <= 3'(NMASTERS - 1);
      r_wait         <= '0;
      r_fault_adr    <= '0;
      r_fault_master <= '0;
      r_fault_kind   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if (r_state == S_IDLE && w_arb_any) r_grant <= w_arb_grant;
      if (w_release) r_last <= r_grant;
      if (w_to_err) begin
        r_fault_adr    <= w_adr;
        r_fault_master <= r_grant;
        r_fault_kind   <= w_err_kind;
      end
    end
  end

  assign bus.s_cyc   = w_s_cyc;
  assign bus.s_stb   = w_s_stb;
  assign bus.s_we    = w_s_we;
  assign bus.s_sel   = w_s_sel;
  assign bus.s_adr   = w_s_adr;
  assign bus.s_dat_w = w_s_dat_w;
  assign bus.m_dat_r = w_m_dat_r;
  assign bus.m_ack   = w_m_ack;
  assign bus.m_err   = w_m_err;
  assign fault        = w_fault;
  assign fault_adr    = r_fault_adr;
  assign fault_master = r_fault_master;
  assign fault_kind   = r_fault_kind;
endmodule

// File: tb/tb_wb_xbar_mmu.sv
// Directed bench for wb_xbar_mmu: a table of single transactions with
// hand-computed outcomes, plus sequences for reset, round-robin and abort.
module tb_wb_xbar_mmu;
  localparam int unsigned NM = 3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        fault;
  logic [31:0] fault_adr;
  logic [2:0]  fault_master;
  logic        fault_kind;

  wb_xbar_mmu_if #(.NMASTERS(NM)) bus ();

  wb_xbar_mmu #(
    .NMASTERS (NM),
    .BASE     (28),
    .SLOT_MASK(16'h0089),
    .TIMEOUT  (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .bus         (bus),
    .fault       (fault),
    .fault_adr   (fault_adr),
    .fault_master(fault_master),
    .fault_kind  (fault_kind)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int unsigned m;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wd;
    int unsigned delay;
    logic [31:0] rd;
    logic        exp_ack;
    logic        exp_err;
    logic        exp_kind;
    logic [15:0] exp_mask;
    int unsigned exp_stb_cycles;
    int unsigned exp_resp;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_master(input int unsigned m, input logic cyc, input logic stb,
                            input logic we, input logic [3:0] sel,
                            input logic [31:0] adr, input logic [31:0] wd);
    logic [NM-1:0]    b;
    logic [4*NM-1:0]  sm;
    logic [32*NM-1:0] am;
    b = '0;
    b[0] = 1'b1;
    b = b << m;
    bus.m_cyc = cyc ? (bus.m_cyc | b) : (bus.m_cyc & ~b);
    bus.m_stb = stb ? (bus.m_stb | b) : (bus.m_stb & ~b);
    bus.m_we  = we  ? (bus.m_we  | b) : (bus.m_we  & ~b);
    sm = {{(4*NM-4){1'b0}}, 4'hf} << (4*m);
    bus.m_sel = (bus.m_sel & ~sm) | ({{(4*NM-4){1'b0}}, sel} << (4*m));
    am = {{(32*NM-32){1'b0}}, 32'hffff_ffff} << (32*m);
    bus.m_adr   = (bus.m_adr & ~am)   | ({{(32*NM-32){1'b0}}, adr} << (32*m));
    bus.m_dat_w = (bus.m_dat_w & ~am) | ({{(32*NM-32){1'b0}}, wd}  << (32*m));
  endtask

  task automatic clear_inputs();
    bus.m_cyc   = '0;
    bus.m_stb   = '0;
    bus.m_we    = '0;
    bus.m_sel   = '0;
    bus.m_adr   = '0;
    bus.m_dat_w = '0;
    bus.s_ack   = '0;
    bus.s_dat_r = '0;
  endtask

  task automatic reset_pulse();
    @(negedge clk_i);
    rst_i = 1'b0;
    clear_inputs();
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int unsigned   slot;
    logic [15:0]   seen;
    logic [15:0]   one16;
    logic [NM-1:0] mbit;
    int unsigned   stb_cyc;
    int            resp;
    logic          got_ack, got_err, other, first;
    int unsigned   fault_cycles;
    logic [31:0]   rdat, sadr, sdat;
    logic          swe;
    logic [3:0]    ssel;
    string         p;
    p = $sformatf("v%0d_", idx);
    slot = 32'(v.adr[31:28]);
    seen = '0; stb_cyc = 0; resp = -1; got_ack = 0; got_err = 0; other = 0;
    first = 1; fault_cycles = 0; rdat = '0; sadr = '0; sdat = '0; swe = 0; ssel = '0;
    one16 = 16'h0001;
    mbit = '0; mbit[0] = 1'b1; mbit = mbit << v.m;
    @(posedge clk_i); #1;
    set_master(v.m, 1'b1, 1'b1, v.we, v.sel, v.adr, v.wd);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_i); #1;
      bus.s_ack = '0;
      if (bus.s_stb != 16'h0) begin
        seen = seen | bus.s_stb;
        if (first) begin
          first = 0; sadr = bus.s_adr; sdat = bus.s_dat_w; swe = bus.s_we; ssel = bus.s_sel;
        end
        if (stb_cyc == v.delay) begin
          bus.s_ack   = one16 << slot;
          bus.s_dat_r = {480'b0, v.rd} << (32*slot);
        end
        stb_cyc++;
      end
      @(negedge clk_i);
      if (((bus.m_ack | bus.m_err) & ~mbit) != '0) other = 1;
      if (fault) fault_cycles++;
      if ((bus.m_ack & mbit) != '0) begin got_ack = 1; rdat = bus.m_dat_r; end
      if ((bus.m_err & mbit) != '0) got_err = 1;
      if (got_ack || got_err) begin resp = c; break; end
    end
    @(posedge clk_i); #1;
    set_master(v.m, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    bus.s_ack = '0;
    bus.s_dat_r = '0;
    @(negedge clk_i);
    chk({p, "after_err"},   32'({bus.m_err != '0, bus.m_ack != '0, fault}), 32'h0);
    chk({p, "ack"},         32'(got_ack), 32'(v.exp_ack));
    chk({p, "err"},         32'(got_err), 32'(v.exp_err));
    chk({p, "resp_cycle"},  32'(resp), 32'(v.exp_resp));
    chk({p, "stb_mask"},    32'(seen), 32'(v.exp_mask));
    chk({p, "stb_cycles"},  32'(stb_cyc), 32'(v.exp_stb_cycles));
    chk({p, "other_resp"},  32'(other), 32'h0);
    chk({p, "fault_pulse"}, 32'(fault_cycles), 32'(v.exp_err));
    if (v.exp_ack) chk({p, "rdata"}, rdat, v.rd);
    if (v.exp_mask != 16'h0) begin
      chk({p, "s_adr"},   sadr, v.adr);
      chk({p, "s_dat_w"}, sdat, v.wd);
      chk({p, "s_we"},    32'(swe), 32'(v.we));
      chk({p, "s_sel"},   32'(ssel), 32'(v.sel));
    end
    if (v.exp_err) begin
      chk({p, "fault_adr"},    fault_adr, v.adr);
      chk({p, "fault_master"}, 32'(fault_master), v.m);
      chk({p, "fault_kind"},   32'(fault_kind), 32'(v.exp_kind));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int unsigned order[6];
    int          n_gr;
    int          overlap;
    int          err_seen;
    logic [NM-1:0] acked_prev;

    vt[0] = '{m:0, adr:32'h3000_0010, we:0, sel:4'hf, wd:32'h0,         delay:2,  rd:32'hDEAD_BEEF,
              exp_ack:1, exp_err:0, exp_kind:0, exp_mask:16'h0008, exp_stb_cycles:3, exp_resp:2};
    vt[1] = '{m:1, adr:32'h0000_0004, we:1, sel:4'h3, wd:32'h1234_5678, delay:0,  rd:32'hA5A5_A5A5,
              exp_ack:1, exp_err:0, exp_kind:0, exp_mask:16'h0001, exp_stb_cycles:1, exp_resp:0};
    vt[2] = '{m:2, adr:32'h7000_ABCC, we:0, sel:4'hf, wd:32'h0,         delay:5,  rd:32'h0BAD_F00D,
              exp_ack:1, exp_err:0, exp_kind:0, exp_mask:16'h0080, exp_stb_cycles:6, exp_resp:5};
    vt[3] = '{m:0, adr:32'h5000_0000, we:0, sel:4'hf, wd:32'h0,         delay:0,  rd:32'h0,
              exp_ack:0, exp_err:1, exp_kind:0, exp_mask:16'h0000, exp_stb_cycles:0, exp_resp:1};
    vt[4] = '{m:1, adr:32'hF000_0020, we:1, sel:4'hc, wd:32'hCAFE_F00D, delay:0,  rd:32'h0,
              exp_ack:0, exp_err:1, exp_kind:0, exp_mask:16'h0000, exp_stb_cycles:0, exp_resp:1};
    vt[5] = '{m:2, adr:32'h7000_0000, we:0, sel:4'hf, wd:32'h0,         delay:99, rd:32'h0,
              exp_ack:0, exp_err:1, exp_kind:1, exp_mask:16'h0080, exp_stb_cycles:9, exp_resp:9};
    vt[6] = '{m:0, adr:32'h37FF_FFFC, we:1, sel:4'h5, wd:32'h0102_0304, delay:7,  rd:32'h1122_3344,
              exp_ack:1, exp_err:0, exp_kind:0, exp_mask:16'h0008, exp_stb_cycles:8, exp_resp:7};

    clear_inputs();
    #1 rst_i = 1'b0;
    #1;
    chk("rst0_s_cyc", 32'(bus.s_cyc), 32'h0);
    chk("rst0_s_stb", 32'(bus.s_stb), 32'h0);
    chk("rst0_m_ack_err", 32'({bus.m_ack, bus.m_err}), 32'h0);
    chk("rst0_fault", 32'({fault, fault_kind, fault_master}), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;

    foreach (vt[i]) run_vec(vt[i], i);

    // Reset asserted in the middle of a stalled transfer
    @(posedge clk_i); #1;
    set_master(1, 1'b1, 1'b1, 1'b0, 4'hf, 32'h3000_0000, 32'h0);
    repeat (3) @(posedge clk_i);
    #2;
    chk("pre_reset_stb", 32'(bus.s_stb), 32'h0008);
    rst_i = 1'b0;
    #1;
    chk("rst_s_cyc",        32'(bus.s_cyc), 32'h0);
    chk("rst_s_stb",        32'(bus.s_stb), 32'h0);
    chk("rst_m_ack",        32'(bus.m_ack), 32'h0);
    chk("rst_m_err",        32'(bus.m_err), 32'h0);
    chk("rst_fault",        32'(fault), 32'h0);
    chk("rst_fault_adr",    fault_adr, 32'h0);
    chk("rst_fault_master", 32'(fault_master), 32'h0);
    chk("rst_fault_kind",   32'(fault_kind), 32'h0);
    chk("rst_s_adr",        bus.s_adr, 32'h0);
    set_master(0, 1'b1, 1'b1, 1'b0, 4'hf, 32'h0000_0100, 32'h0);
    set_master(1, 1'b1, 1'b1, 1'b0, 4'hf, 32'h0000_0200, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("first_grant_adr", bus.s_adr, 32'h0000_0100);
    chk("first_grant_cyc", 32'(bus.s_cyc), 32'h0001);
    reset_pulse();

    // Round-robin with all three masters re-requesting after every ack
    n_gr = 0; overlap = 0; acked_prev = '0;
    for (int c = 0; c < 80 && n_gr < 6; c++) begin
      @(posedge clk_i); #1;
      for (int unsigned i = 0; i < NM; i++) begin
        logic [NM-1:0] t;
        t = acked_prev >> i;
        set_master(i, !t[0], !t[0], 1'b0, 4'hf, 32'h0000_0010 * (i + 1), 32'h0);
      end
      #1;
      bus.s_ack = bus.s_stb & 16'h0001;
      @(negedge clk_i);
      if ($countones(bus.m_ack) > 1) overlap++;
      acked_prev = bus.m_ack;
      for (int unsigned i = 0; i < NM; i++) begin
        logic [NM-1:0] t;
        t = bus.m_ack >> i;
        if (t[0] && n_gr < 6) begin order[n_gr] = i; n_gr++; end
      end
    end
    chk("rr_grants", 32'(n_gr), 32'd6);
    for (int k = 0; k < 6; k++) chk($sformatf("rr_order%0d", k), order[k], k % 3);
    chk("rr_overlap", 32'(overlap), 32'h0);
    reset_pulse();

    // Abort: master 0 drops cyc while slot 3 stalls; master 1 waits
    err_seen = 0;
    @(posedge clk_i); #1;
    set_master(0, 1'b1, 1'b1, 1'b0, 4'hf, 32'h3000_0000, 32'h0);
    set_master(1, 1'b1, 1'b1, 1'b1, 4'hf, 32'h0000_0040, 32'h0000_0055);
    @(posedge clk_i); #1;
    chk("abort_grant_stb", 32'(bus.s_stb), 32'h0008);
    @(negedge clk_i); if (bus.m_err != '0) err_seen++;
    @(posedge clk_i); #1;
    set_master(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("abort_scyc_same_cycle", 32'(bus.s_cyc), 32'h0);
    @(negedge clk_i); if (bus.m_err != '0) err_seen++;
    @(posedge clk_i); #1;
    chk("abort_idle_scyc", 32'(bus.s_cyc), 32'h0);
    @(negedge clk_i); if (bus.m_err != '0) err_seen++;
    @(posedge clk_i); #1;
    chk("abort_regrant_cyc", 32'(bus.s_cyc), 32'h0001);
    chk("abort_regrant_adr", bus.s_adr, 32'h0000_0040);
    bus.s_ack = 16'h0001;
    @(negedge clk_i);
    if (bus.m_err != '0) err_seen++;
    chk("abort_m1_ack", 32'(bus.m_ack), 32'h2);
    chk("abort_no_err", 32'(err_seen), 32'h0);
    @(posedge clk_i); #1;
    set_master(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    bus.s_ack = '0;
    repeat (2) @(posedge clk_i);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/wb_xbar_mmu.md
# wb_xbar_mmu

Parametrised Wishbone interconnect and successor to the fixed single-master `mmu`. It arbitrates NMASTERS classic-cycle masters onto one shared path, round-robin with the grant held for the whole `cyc`. It decodes a 4-bit page field to 16 slave slots. Unpopulated slots and stalled slaves produce a bus error instead of hanging. A fault capture supplies the MMU/bus-error interrupt to `interrupt_encoder`, replacing the ad-hoc combinational `bus0_error` in the top level.

## Interface
- NMASTERS, 2: number of masters, 1–8.
- BASE, 28: LSB of the 4-bit slot field `adr[BASE+3:BASE]`.
- SLOT_MASK, 16'hffff: bit k=1 means slot k is populated.
- TIMEOUT, 255: maximum cycles a granted `stb` may wait for `ack`, 1–65535.
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-low reset.
- m_cyc, m_stb, m_we  in  NMASTERS  per-master Wishbone controls.
- m_sel  in  4*NMASTERS  byte selects; master i is at [4i+3:4i].
- m_adr, m_dat_w  in  32*NMASTERS  address and write data, packed per master.
- m_dat_r  out  32  read data, broadcast to all masters.
- m_ack, m_err  out  NMASTERS  per-master acknowledge and error.
- s_cyc, s_stb  out  16  per-slot controls.
- s_we  out  1  shared write enable.
- s_sel  out  4  shared byte selects.
- s_adr, s_dat_w  out  32  shared address and write data.
- s_dat_r  in  512  slot k read data at [32k+31:32k].
- s_ack  in  16  per-slot acknowledge.
- fault  out  1  one-cycle pulse on every error response.
- fault_adr  out  32  address of the most recent error.
- fault_master  out  3  index of the master that took the most recent error.
- fault_kind  out  1  0 = unmapped slot, 1 = timeout.

## Operation
- **States:** IDLE, ACTIVE, ERR.
- **IDLE:**
  - When any `m_cyc` is high, grant the first requesting master after `last`, scanning cyclically.
  - Register the grant and go to ACTIVE.
  - No slave-side signal is asserted in IDLE.
- **ACTIVE, pass-through path:**
  - The granted master's `we/sel/adr/dat_w` drive the shared slave outputs.
  - Decoded slot k = `adr[BASE+3:BASE]`.
  - `s_cyc[k]` = `m_cyc[g]` and `s_stb[k]` = `m_stb[g]`; all other slots are 0.
  - `m_ack[g]` = `s_ack[k]` and `m_dat_r` = `s_dat_r[k]`.
  - Every non-granted `m_ack` and `m_err` stays 0.
- **ACTIVE, unmapped slot:** if `m_stb[g]` is high and `SLOT_MASK[k]` = 0, no `s_cyc`/`s_stb` is driven; go to ERR with `fault_kind` = 0.
- **ACTIVE, timeout:**
  - A 16-bit wait counter clears on `ack`, on `stb` low, and on any state entry.
  - It increments on every cycle with `m_stb[g]` high and `s_ack[k]` low.
  - When the counter reaches TIMEOUT, drop `s_cyc`/`s_stb` and go to ERR with `fault_kind` = 1.
- **ERR (exactly one cycle):**
  - `m_err[g]` = 1 and `fault` = 1.
  - Latch `fault_adr` = `m_adr[g]` and `fault_master` = g.
  - All `s_stb` are 0.
  - Return to ACTIVE.
- **Release:** in ACTIVE, `m_cyc[g]` low causes `s_cyc` to drop in the same cycle (combinationally); next edge sets `last` = g and goes to IDLE.
- `m_cyc[g]` dropping during ERR: `m_err` still pulses; the block then goes to IDLE.
- Unmapped takes priority over timeout on the same cycle.
- Classic cycles only: one outstanding transfer; `stb` is held until `ack` or `err`.

## Timing
- **Reset values:**
  - All `s_cyc`, `s_stb`, `m_ack`, `m_err` and `fault` = 0.
  - `fault_adr`, `fault_master`, `fault_kind`, the wait counter and the grant = 0.
  - `last` = NMASTERS-1, so master 0 wins the first arbitration.
  - State = IDLE.
  - Reset asserted mid-transfer clears all of the above immediately (asynchronously), without waiting for an edge.
- **Grant latency:** `m_cyc` rising at edge n gives grant at edge n+1; the slave sees `cyc`/`stb` during cycle n+1.
- **Acknowledge:** `ack` is combinational slave→master, zero added cycles; back-to-back `stb` within one `cyc` needs no re-arbitration.
- **Unmapped error:** `m_err` is asserted the cycle after the grant and `stb` are present.
- **Timeout error:** `m_err` is asserted TIMEOUT+1 cycles after `stb` first reaches the slave.
- A master that loses arbitration waits; its `m_cyc` remains asserted and it is never dropped.
- **Round-robin fairness:** with all masters requesting continuously, each master receives a grant within NMASTERS arbitrations.

## Test plan
- **Reset state:** assert `rst_i` mid-transfer → every output is 0 asynchronously; after release, master 0 is granted first.
- **Mapped read:** master 0 reads 0x30000010 with SLOT_MASK=16'h0089 and slot 3 acking after 2 cycles with 0xDEADBEEF → `s_stb[3]` only; `m_dat_r`=0xDEADBEEF; `m_ack[0]` 1 cycle; no fault.
- **Unmapped access:** access 0x50000000 → no `s_stb`; `m_err` for one cycle; `fault`=1; `fault_adr`=0x50000000; `fault_kind`=0.
- **Timeout:** TIMEOUT=8, slot 7 never acks → `s_stb[7]` high 9 cycles, then drops; `m_err` for one cycle; `fault_kind`=1.
- **Round-robin:** NMASTERS=3, all masters issuing single-word `cyc` repeatedly → grant order 0,1,2,0,1,2; no overlap of `m_ack`.
- **Abort:** master drops `cyc` while the slave is stalled → `s_cyc` low the same cycle; the other master is granted 2 edges later; no `err`.
